// File: rtl/pe_feeder_if.sv
// pe_feeder_if: control/data link between the cluster-side feeder (initiator)
// and one PE column-bottom slot.
//   master (feeder): drives weight/activation streams, load/start/sums
//                    strobes, the latched counts and the column-bottom psum;
//                    receives done, psum and psum valid from the PE.
//   slave  (PE):     the mirror image.
interface pe_feeder_if #(
  parameter int dataSize   = 8,
  parameter int macResSize = 2*dataSize+4
);
  logic [dataSize-1:0]   pe_weights_o;
  logic [dataSize-1:0]   pe_acts_o;
  logic [macResSize-1:0] pe_psum_o;
  logic                  pe_loadw_o;
  logic                  pe_loada_o;
  logic                  pe_start_o;
  logic                  pe_sums_o;
  logic [7:0]            pe_wcount_o;
  logic [7:0]            pe_acount_o;
  logic                  pe_done_i;
  logic [macResSize-1:0] pe_psum_i;
  logic                  pe_psum_valid_i;

  modport master (
    output pe_weights_o, pe_acts_o, pe_psum_o, pe_loadw_o, pe_loada_o,
           pe_start_o, pe_sums_o, pe_wcount_o, pe_acount_o,
    input  pe_done_i, pe_psum_i, pe_psum_valid_i
  );

  modport slave (
    input  pe_weights_o, pe_acts_o, pe_psum_o, pe_loadw_o, pe_loada_o,
           pe_start_o, pe_sums_o, pe_wcount_o, pe_acount_o,
    output pe_done_i, pe_psum_i, pe_psum_valid_i
  );
endinterface

// File: rtl/pe_feeder.sv
// pe_feeder: sequences one 1D-convolution job through a PE column-bottom slot.
// The host fills the weight/activation buffers while idle and pulses start;
// the feeder streams weights, then activations, issues the compute start,
// waits for the PE to finish (or a timeout), runs the psum readout and
// returns one result word per output position.
// Ports:
//   clk, nrst               clock, asynchronous active-low reset
//   start, cfg_wcount/acount job request and filter/activation lengths
//   wbuf_*, abuf_*          host write ports of the two local buffers
//   busy, done, err_cfg     job status (done/err_cfg are one-cycle pulses)
//   res_valid/data/idx      result strobe, psum and output position
//   pe                      master end of the PE link
// Every output is a flop whose next value is decoded from the current state,
// so PE-facing strobes appear one cycle after the state that issues them.
module pe_feeder #(
  parameter int dataSize   = 8,
  parameter int macResSize = 2*dataSize+4,
  parameter int bufDepth   = 16
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic                        start,
  input  logic [7:0]                  cfg_wcount,
  input  logic [7:0]                  cfg_acount,
  input  logic                        wbuf_wr_en,
  input  logic [$clog2(bufDepth)-1:0] wbuf_addr,
  input  logic [dataSize-1:0]         wbuf_wr_data,
  input  logic                        abuf_wr_en,
  input  logic [$clog2(bufDepth)-1:0] abuf_addr,
  input  logic [dataSize-1:0]         abuf_wr_data,
  output logic                        busy,
  output logic                        done,
  output logic                        err_cfg,
  output logic                        res_valid,
  output logic [macResSize-1:0]       res_data,
  output logic [7:0]                  res_idx,
  pe_feeder_if.master                 pe
);

  localparam int AW = $clog2(bufDepth);
  localparam logic [8:0] DEPTH = 9'(bufDepth);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_LOAD_W = 4'd1;
  localparam logic [3:0] S_GAP_W  = 4'd2;
  localparam logic [3:0] S_LOAD_A = 4'd3;
  localparam logic [3:0] S_GAP_A  = 4'd4;
  localparam logic [3:0] S_START  = 4'd5;
  localparam logic [3:0] S_WAIT   = 4'd6;
  localparam logic [3:0] S_SUMS   = 4'd7;
  localparam logic [3:0] S_DRAIN  = 4'd8;
  localparam logic [3:0] S_FIN    = 4'd9;

  logic [3:0]            state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [7:0]            w_q, w_d;
  logic [7:0]            a_q, a_d;
  logic [7:0]            n_q, n_d;
  logic [15:0]           tmo_q, tmo_d;
  logic                  done_prev_q, done_prev_d;
  logic                  sums_dly_q, sums_dly_d;
  logic [7:0]            k_q, k_d;
  logic [dataSize-1:0]   wbuf_q [bufDepth];
  logic [dataSize-1:0]   wbuf_d [bufDepth];
  logic [dataSize-1:0]   abuf_q [bufDepth];
  logic [dataSize-1:0]   abuf_d [bufDepth];

  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  res_valid_q, res_valid_d;
  logic [macResSize-1:0] res_data_q, res_data_d;
  logic [7:0]            res_idx_q, res_idx_d;
  logic [dataSize-1:0]   weights_q, weights_d;
  logic [dataSize-1:0]   acts_q, acts_d;
  logic                  loadw_q, loadw_d;
  logic                  loada_q, loada_d;
  logic                  start_q, start_d;
  logic                  sums_q, sums_d;

  logic                  bad_cfg;

  assign bad_cfg = (cfg_wcount == 8'd0) || (cfg_wcount > cfg_acount) ||
                   ({1'b0, cfg_acount} > DEPTH);

  // Host writes land only while idle; anything written during a job is lost.
  always_comb begin
    wbuf_d = wbuf_q;
    abuf_d = abuf_q;
    if (state_q == S_IDLE) begin
      if (wbuf_wr_en) wbuf_d[wbuf_addr] = wbuf_wr_data;
      if (abuf_wr_en) abuf_d[abuf_addr] = abuf_wr_data;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    w_d         = w_q;
    a_d         = a_q;
    n_d         = n_q;
    tmo_d       = tmo_q;
    k_d         = k_q;
    done_prev_d = pe.pe_done_i;
    sums_dly_d  = sums_q;

    busy_d      = (state_q != S_IDLE) && (state_q != S_FIN);
    done_d      = 1'b0;
    err_d       = 1'b0;
    res_valid_d = 1'b0;
    res_data_d  = '0;
    res_idx_d   = '0;
    weights_d   = '0;
    acts_d      = '0;
    loadw_d     = 1'b0;
    loada_d     = 1'b0;
    start_d     = 1'b0;
    sums_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (bad_cfg) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            w_d     = cfg_wcount;
            a_d     = cfg_acount;
            n_d     = cfg_acount - cfg_wcount + 8'd1;
            cnt_d   = '0;
            k_d     = '0;
            state_d = S_LOAD_W;
          end
        end
      end
      S_LOAD_W: begin
        weights_d = wbuf_q[cnt_q[AW-1:0]];
        loadw_d   = (cnt_q == 8'd0);
        if (cnt_q == w_q - 8'd1) begin
          cnt_d   = '0;
          state_d = S_GAP_W;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_GAP_W: begin
        if (cnt_q == 8'd1) begin
          cnt_d   = '0;
          state_d = S_LOAD_A;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_LOAD_A: begin
        acts_d  = abuf_q[cnt_q[AW-1:0]];
        loada_d = (cnt_q == 8'd0);
        if (cnt_q == a_q - 8'd1) begin
          cnt_d   = '0;
          state_d = S_GAP_A;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_GAP_A: begin
        if (cnt_q == 8'd1) begin
          cnt_d   = '0;
          state_d = S_START;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_START: begin
        // done_prev captures the PE done level here, so WAIT only reacts to
        // a fresh rising edge; a level stuck high falls through to timeout.
        start_d = 1'b1;
        tmo_d   = {8'd0, n_q} * {8'd0, w_q} + 16'd8;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        tmo_d = tmo_q - 16'd1;
        // Exiting on tmo_q==1 keeps WAIT for exactly the loaded count.
        if ((pe.pe_done_i && !done_prev_q) || (tmo_q == 16'd1)) begin
          cnt_d   = '0;
          state_d = S_SUMS;
        end
      end
      S_SUMS: begin
        sums_d = 1'b1;
        if (cnt_q == n_q - 8'd1) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DRAIN: begin
        // Two cycles let the last readout sample and its result register land.
        if (cnt_q == 8'd1) begin
          cnt_d   = '0;
          state_d = S_FIN;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // The PE answers each sums strobe one cycle later, so the capture slot
    // trails the registered strobe by one cycle. Position k advances per
    // slot whether or not the PE marked the sample valid.
    if (sums_dly_q) begin
      k_d = k_q + 8'd1;
      if (pe.pe_psum_valid_i) begin
        res_valid_d = 1'b1;
        res_data_d  = pe.pe_psum_i;
        res_idx_d   = k_q;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      w_q         <= '0;
      a_q         <= '0;
      n_q         <= '0;
      tmo_q       <= '0;
      k_q         <= '0;
      done_prev_q <= 1'b0;
      sums_dly_q  <= 1'b0;
      wbuf_q      <= '{default: '0};
      abuf_q      <= '{default: '0};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_idx_q   <= '0;
      weights_q   <= '0;
      acts_q      <= '0;
      loadw_q     <= 1'b0;
      loada_q     <= 1'b0;
      start_q     <= 1'b0;
      sums_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      w_q         <= w_d;
      a_q         <= a_d;
      n_q         <= n_d;
      tmo_q       <= tmo_d;
      k_q         <= k_d;
      done_prev_q <= done_prev_d;
      sums_dly_q  <= sums_dly_d;
      wbuf_q      <= wbuf_d;
      abuf_q      <= abuf_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_idx_q   <= res_idx_d;
      weights_q   <= weights_d;
      acts_q      <= acts_d;
      loadw_q     <= loadw_d;
      loada_q     <= loada_d;
      start_q     <= start_d;
      sums_q      <= sums_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign err_cfg         = err_q;
  assign res_valid       = res_valid_q;
  assign res_data        = res_data_q;
  assign res_idx         = res_idx_q;
  assign pe.pe_weights_o = weights_q;
  assign pe.pe_acts_o    = acts_q;
  assign pe.pe_psum_o    = '0;
  assign pe.pe_loadw_o   = loadw_q;
  assign pe.pe_loada_o   = loada_q;
  assign pe.pe_start_o   = start_q;
  assign pe.pe_sums_o    = sums_q;
  assign pe.pe_wcount_o  = w_q;
  assign pe.pe_acount_o  = a_q;

endmodule

// File: tb/tb_pe_feeder.sv
// tb_pe_feeder: directed bench for pe_feeder with a behavioural PE model and
// a result scoreboard filled from the bench's own copy of the buffers.
module tb_pe_feeder;

  logic        clk = 1'b0;
  logic        nrst;
  logic        start;
  logic [7:0]  cfg_wcount, cfg_acount;
  logic        wbuf_wr_en, abuf_wr_en;
  logic [3:0]  wbuf_addr, abuf_addr;
  logic [7:0]  wbuf_wr_data, abuf_wr_data;
  logic        busy, done, err_cfg, res_valid;
  logic [19:0] res_data;
  logic [7:0]  res_idx;

  pe_feeder_if pif ();

  pe_feeder dut (
    .clk(clk), .nrst(nrst), .start(start),
    .cfg_wcount(cfg_wcount), .cfg_acount(cfg_acount),
    .wbuf_wr_en(wbuf_wr_en), .wbuf_addr(wbuf_addr), .wbuf_wr_data(wbuf_wr_data),
    .abuf_wr_en(abuf_wr_en), .abuf_addr(abuf_addr), .abuf_wr_data(abuf_wr_data),
    .busy(busy), .done(done), .err_cfg(err_cfg),
    .res_valid(res_valid), .res_data(res_data), .res_idx(res_idx),
    .pe(pif)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_res_cyc = 0;
  int wmem [16];
  int amem [16];
  int wcap [16];
  int acap [16];
  int wl = 0, al = 0, pk = 0, dly = 0;
  bit sticky = 1'b0;
  int drop_k = -1;
  int exp_idx [$];
  int exp_data [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc++;

  // Behavioural PE: captures the streams, pulses done a few cycles after
  // start (or holds it high in sticky mode), and answers each sums strobe
  // with the next convolution output one cycle later.
  function automatic int conv_cap(input int k);
    int s = 0;
    for (int j = 0; j < int'(pif.pe_wcount_o); j++) s += wcap[j] * acap[k + j];
    return s;
  endfunction

  always @(posedge clk) begin
    if (!nrst) begin
      wl = 0; al = 0; pk = 0; dly = 0;
      pif.pe_done_i       <= 1'b0;
      pif.pe_psum_i       <= '0;
      pif.pe_psum_valid_i <= 1'b0;
    end else begin
      if (pif.pe_loadw_o) begin wcap[0] = int'(pif.pe_weights_o); wl = 1; end
      else if (wl > 0 && wl < int'(pif.pe_wcount_o)) begin wcap[wl] = int'(pif.pe_weights_o); wl++; end
      else wl = 0;
      if (pif.pe_loada_o) begin acap[0] = int'(pif.pe_acts_o); al = 1; end
      else if (al > 0 && al < int'(pif.pe_acount_o)) begin acap[al] = int'(pif.pe_acts_o); al++; end
      else al = 0;
      if (pif.pe_start_o) begin dly = 4; pk = 0; end
      else if (dly > 0) dly--;
      pif.pe_done_i <= sticky || (dly == 1);
      if (pif.pe_sums_o) begin
        pif.pe_psum_i       <= 20'(conv_cap(pk));
        pif.pe_psum_valid_i <= (pk != drop_k);
        pk++;
      end else begin
        pif.pe_psum_valid_i <= 1'b0;
      end
    end
  end

  // Scoreboard consumer: one line per returned result.
  always @(posedge clk) begin
    #1;
    if (res_valid === 1'b1) begin
      last_res_cyc = cyc;
      check("res_expected", 32'(exp_idx.size() > 0), 1);
      if (exp_idx.size() > 0) begin
        check("res_idx", 32'(res_idx), 32'(exp_idx[0]));
        check("res_data", 32'(res_data), 32'(exp_data[0]));
        $display("result idx=%0d data=%0d (expected idx=%0d data=%0d)",
                 res_idx, res_data, exp_idx[0], exp_data[0]);
        void'(exp_idx.pop_front());
        void'(exp_data.pop_front());
      end
    end
  end

  function automatic int exp_conv(input int w, input int k);
    int s = 0;
    for (int j = 0; j < w; j++) s += wmem[j] * amem[k + j];
    return s;
  endfunction

  task automatic push_expected(input int w, input int a, input int skip);
    for (int k = 0; k <= a - w; k++)
      if (k != skip) begin
        exp_idx.push_back(k);
        exp_data.push_back(exp_conv(w, k));
      end
  endtask

  task automatic wr_w(input int addr, input int data);
    wbuf_addr = 4'(addr); wbuf_wr_data = 8'(data); wbuf_wr_en = 1'b1;
    tick();
    wbuf_wr_en = 1'b0;
    wmem[addr] = data;
  endtask

  task automatic wr_a(input int addr, input int data);
    abuf_addr = 4'(addr); abuf_wr_data = 8'(data); abuf_wr_en = 1'b1;
    tick();
    abuf_wr_en = 1'b0;
    amem[addr] = data;
  endtask

  function automatic bit sig_sel(input int which);
    case (which)
      0: return done === 1'b1;
      1: return pif.pe_loada_o === 1'b1;
      2: return pif.pe_start_o === 1'b1;
      default: return pif.pe_sums_o === 1'b1;
    endcase
  endfunction

  // Bounded wait; an expired budget is reported as a failed check.
  task automatic wait_for(input int which, input int budget, input string tag, output int at);
    bit found = 1'b0;
    at = cyc;
    for (int i = 0; i < budget && !found; i++) begin
      tick();
      if (sig_sel(which)) begin found = 1'b1; at = cyc; end
    end
    check(tag, 32'(found), 1);
  endtask

  task automatic kick(input int w, input int a, output int s_cyc);
    cfg_wcount = 8'(w); cfg_acount = 8'(a); start = 1'b1;
    tick();
    start = 1'b0;
    s_cyc = cyc;
  endtask

  int s_cyc, d_cyc, t0, t1, basic_off;
  int bad_w [3] = '{0, 4, 3};
  int bad_a [3] = '{5, 3, 17};

  initial begin
    nrst = 1'b0; start = 1'b0; cfg_wcount = '0; cfg_acount = '0;
    wbuf_wr_en = 1'b0; abuf_wr_en = 1'b0; wbuf_addr = '0; abuf_addr = '0;
    wbuf_wr_data = '0; abuf_wr_data = '0;
    for (int i = 0; i < 16; i++) begin wmem[i] = 0; amem[i] = 0; end
    repeat (2) tick();

    // Reset state
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_wcount", 32'(pif.pe_wcount_o), 0);
    check("rst_ctrl", 32'({pif.pe_loadw_o, pif.pe_loada_o, pif.pe_start_o, pif.pe_sums_o}), 0);
    nrst = 1'b1;
    tick();

    // Basic job: W=3 {1,2,3}, A=5 {1..5} -> 14, 20, 26
    for (int i = 0; i < 3; i++) wr_w(i, i + 1);
    for (int i = 0; i < 5; i++) wr_a(i, i + 1);
    push_expected(3, 5, -1);
    kick(3, 5, s_cyc);
    tick();
    check("busy_s1", 32'(busy), 1);
    check("loadw_s1", 32'(pif.pe_loadw_o), 1);
    check("weight0", 32'(pif.pe_weights_o), 1);
    for (int j = 1; j < 3; j++) begin
      tick();
      check("loadw_single", 32'(pif.pe_loadw_o), 0);
      check("weight_stream", 32'(pif.pe_weights_o), 32'(j + 1));
    end
    repeat (2) begin
      tick();
      check("gap_w_ctrl", 32'({pif.pe_loadw_o, pif.pe_loada_o}), 0);
    end
    tick();
    check("loada_cycle", 32'(pif.pe_loada_o), 1);
    check("act0", 32'(pif.pe_acts_o), 1);
    for (int j = 1; j < 5; j++) begin
      tick();
      check("loada_single", 32'(pif.pe_loada_o), 0);
      check("act_stream", 32'(pif.pe_acts_o), 32'(j + 1));
    end
    repeat (2) begin
      tick();
      check("gap_a_start", 32'(pif.pe_start_o), 0);
    end
    tick();
    check("start_cycle", 32'(pif.pe_start_o), 1);
    check("wcount_o", 32'(pif.pe_wcount_o), 3);
    check("acount_o", 32'(pif.pe_acount_o), 5);
    wait_for(0, 200, "basic_done_seen", d_cyc);
    basic_off = d_cyc - s_cyc;
    check("done_after_last_res", 32'(d_cyc - last_res_cyc), 1);
    check("busy_at_done", 32'(busy), 0);
    check("basic_all_results", 32'(exp_idx.size()), 0);
    tick();
    check("done_one_cycle", 32'(done), 0);

    // Config errors: W=0, W>A, A>bufDepth
    for (int c = 0; c < 3; c++) begin
      kick(bad_w[c], bad_a[c], s_cyc);
      check("err_done", 32'(done), 1);
      check("err_flag", 32'(err_cfg), 1);
      check("err_busy", 32'(busy), 0);
      check("err_ctrl", 32'({pif.pe_loadw_o, pif.pe_loada_o, pif.pe_start_o, pif.pe_sums_o}), 0);
      check("err_wcount_held", 32'(pif.pe_wcount_o), 3);
      tick();
      check("err_done_pulse", 32'(done), 0);
      check("err_busy_after", 32'(busy), 0);
      check("err_ctrl_after", 32'({pif.pe_loadw_o, pif.pe_loada_o}), 0);
    end

    // Start and weight write while busy are ignored
    push_expected(3, 5, -1);
    kick(3, 5, s_cyc);
    wait_for(1, 50, "busy_loada_seen", t0);
    start = 1'b1; wbuf_addr = 4'd0; wbuf_wr_data = 8'd99; wbuf_wr_en = 1'b1;
    tick();
    start = 1'b0; wbuf_wr_en = 1'b0;
    wait_for(0, 200, "busy_job_done", d_cyc);
    check("busy_job_results", 32'(exp_idx.size()), 0);
    repeat (3) tick();
    check("no_second_job", 32'(busy), 0);
    push_expected(3, 5, -1);
    kick(3, 5, s_cyc);
    tick();
    check("wbuf0_kept", 32'(pif.pe_weights_o), 1);
    wait_for(0, 200, "rerun_done", d_cyc);
    check("rerun_results", 32'(exp_idx.size()), 0);

    // Sticky done: WAIT lasts N*W+8 = 14 cycles, so sums rises 15 cycles
    // after the start strobe.
    sticky = 1'b1;
    tick();
    push_expected(2, 4, -1);
    kick(2, 4, s_cyc);
    wait_for(2, 50, "sticky_start_seen", t0);
    wait_for(3, 50, "sticky_sums_seen", t1);
    check("sticky_wait_len", 32'(t1 - t0), 15);
    wait_for(0, 100, "sticky_done", d_cyc);
    check("sticky_results", 32'(exp_idx.size()), 0);
    sticky = 1'b0;
    repeat (2) tick();

    // Missing valid on k=1: only idx 0 and 2 return, done timing unchanged
    drop_k = 1;
    push_expected(3, 5, 1);
    kick(3, 5, s_cyc);
    wait_for(0, 200, "drop_done", d_cyc);
    check("drop_done_timing", 32'(d_cyc - s_cyc), 32'(basic_off));
    check("drop_results", 32'(exp_idx.size()), 0);
    drop_k = -1;
    tick();

    // Reset in the middle of LOAD_A
    kick(3, 5, s_cyc);
    wait_for(1, 50, "rst_loada_seen", t0);
    #2;
    nrst = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_loada", 32'(pif.pe_loada_o), 0);
    check("midrst_acts", 32'(pif.pe_acts_o), 0);
    check("midrst_counts", 32'({pif.pe_wcount_o, pif.pe_acount_o}), 0);
    check("midrst_done", 32'(done), 0);
    exp_idx.delete();
    exp_data.delete();
    for (int i = 0; i < 16; i++) begin wmem[i] = 0; amem[i] = 0; end
    tick();
    nrst = 1'b1;
    tick();
    wr_w(0, 1); wr_w(1, 1); wr_a(0, 3); wr_a(1, 4);
    push_expected(2, 2, -1);
    check("post_rst_expect7", 32'(exp_data[0]), 7);
    kick(2, 2, s_cyc);
    wait_for(0, 100, "post_rst_done", d_cyc);
    check("post_rst_results", 32'(exp_idx.size()), 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
